// File: rtl/food_map_server.sv
// Pellet bitmap server: registered renderer row reads plus a 3-cycle eat read-modify-write and refill.
// Latency: rd_row 1 cycle after rd_y; eat accepted at edge N reports eat_hit after edge N+2; refill takes ROWS cycles.
// Backpressure: eat_ready is low outside IDLE and eat_valid is ignored then; a refill requested mid-eat is held until IDLE.
// Optional build macro FOOD_MAP_STATS_EN adds the saturating eaten_total counter.
module food_map_server #(
  parameter int              ROWS     = 60,
  parameter int              COLS     = 80,
  parameter int              Y_W      = 6,
  parameter int              X_W      = 7,
  parameter logic [COLS-1:0] INIT_ROW = {40{2'b01}},
  parameter int              CNT_W    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Y_W-1:0]   rd_y,
  output logic [COLS-1:0]  rd_row,
  input  logic             eat_valid,
  input  logic [X_W-1:0]   eat_x,
  input  logic [Y_W-1:0]   eat_y,
  output logic             eat_ready,
  output logic             eat_hit,
  input  logic             refill_req,
  output logic             busy,
  output logic [CNT_W-1:0] food_left,
  output logic             all_eaten
`ifdef FOOD_MAP_STATS_EN
  ,output logic [15:0]     eaten_total
`endif
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  function automatic int popcnt(input logic [COLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < COLS; i++) n += int'(v[i]);
    return n;
  endfunction

  // Pellet count of a freshly refilled map, fixed at elaboration.
  localparam int               FULL     = ROWS * popcnt(INIT_ROW);
  localparam logic [CNT_W-1:0] FULL_L   = CNT_W'(FULL);
  localparam logic [Y_W:0]     ROWS_L   = (Y_W + 1)'(ROWS);
  localparam logic [X_W:0]     COLS_L   = (X_W + 1)'(COLS);
  localparam logic [AW-1:0]    LAST_ROW = AW'(ROWS - 1);

  typedef enum logic [1:0] {REFILL, IDLE, EAT_RD, EAT_WR} state_e;

  logic [COLS-1:0]  mem_q [ROWS];
  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [X_W-1:0]   ex_q, ex_d;
  logic [Y_W-1:0]   ey_q, ey_d;
  logic [COLS-1:0]  rmw_q, rmw_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] food_q, food_d;
  logic             hit_q, hit_d;
  logic [COLS-1:0]  rd_row_q;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [COLS-1:0]  mem_wd;
  logic             rd_ok, ex_ok, ey_ok;

  assign rd_ok = ({1'b0, rd_y} < ROWS_L);
  assign ey_ok = ({1'b0, ey_q} < ROWS_L);
  assign ex_ok = ({1'b0, ex_q} < COLS_L);

  assign rd_row    = rd_row_q;
  assign eat_hit   = hit_q;
  assign food_left = food_q;
  assign eat_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign all_eaten = (state_q != REFILL) && (food_q == '0);

  // Next-state and RMW datapath; refill wins over a same-cycle eat, which is dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    rmw_d   = rmw_q;
    pend_d  = pend_q;
    food_d  = food_q;
    hit_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = INIT_ROW;
    case (state_q)
      REFILL: begin
        mem_we = 1'b1;
        food_d = '0;
        if (ptr_q == LAST_ROW) begin
          state_d = IDLE;
          food_d  = FULL_L;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      IDLE: begin
        if (refill_req || pend_q) begin
          state_d = REFILL;
          ptr_d   = '0;
          pend_d  = 1'b0;
          food_d  = '0;
        end else if (eat_valid) begin
          ex_d    = eat_x;
          ey_d    = eat_y;
          state_d = EAT_RD;
        end
      end
      EAT_RD: begin
        rmw_d   = ey_ok ? mem_q[ey_q[AW-1:0]] : '0;
        pend_d  = pend_q | refill_req;
        state_d = EAT_WR;
      end
      EAT_WR: begin
        pend_d  = pend_q | refill_req;
        state_d = IDLE;
        if (ex_ok && ey_ok && rmw_q[ex_q[CW-1:0]]) begin
          mem_we                 = 1'b1;
          mem_wa                 = ey_q[AW-1:0];
          mem_wd                 = rmw_q;
          mem_wd[ex_q[CW-1:0]]   = 1'b0;
          hit_d                  = 1'b1;
          food_d                 = food_q - CNT_W'(1);
        end
      end
      default: state_d = REFILL;
    endcase
  end

  // Control and counter registers; reset aborts any operation and restarts refill at row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REFILL;
      ptr_q   <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      rmw_q   <= '0;
      pend_q  <= 1'b0;
      food_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      rmw_q   <= rmw_d;
      pend_q  <= pend_d;
      food_q  <= food_d;
      hit_q   <= hit_d;
    end
  end

  // Single internal write port; suppressed on the reset edge so no partial write lands.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Renderer read port: read-first against a same-edge write, zero for rows past the map.
  always_ff @(posedge clk) begin
    if (rst) rd_row_q <= '0;
    else     rd_row_q <= rd_ok ? mem_q[rd_y[AW-1:0]] : '0;
  end

`ifdef FOOD_MAP_STATS_EN
  logic [15:0] eaten_q;
  assign eaten_total = eaten_q;

  // Lifetime hit counter: survives refills, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                               eaten_q <= '0;
    else if (hit_d && (eaten_q != 16'hFFFF)) eaten_q <= eaten_q + 16'd1;
  end
`else
  // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_food_map_server.sv
// Directed bench for food_map_server: default map plus a 2-row, 1-pellet-per-row instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded so the run always reaches its summary line.
module tb_food_map_server;
  localparam logic [79:0] INIT     = {40{2'b01}};
  localparam logic [79:0] ROW5_EAT = 80'h5555_5555_5555_5555_5554;
  localparam logic [79:0] ROW59_EAT = 80'h1555_5555_5555_5555_5555;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  rd_y = '0;
  logic [79:0] rd_row;
  logic        eat_valid = 1'b0;
  logic [6:0]  eat_x = '0;
  logic [5:0]  eat_y = '0;
  logic        eat_ready, eat_hit, busy, all_eaten;
  logic        refill_req = 1'b0;
  logic [12:0] food_left;
`ifdef FOOD_MAP_STATS_EN
  logic [15:0] eaten_total;
`endif

  logic        rst2 = 1'b1;
  logic [5:0]  rd_y2 = '0;
  logic [79:0] rd_row2;
  logic        eat_valid2 = 1'b0;
  logic [6:0]  eat_x2 = '0;
  logic [5:0]  eat_y2 = '0;
  logic        eat_ready2, eat_hit2, busy2, all_eaten2;
  logic        refill_req2 = 1'b0;
  logic [12:0] food_left2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  food_map_server dut (
    .clk(clk), .rst(rst), .rd_y(rd_y), .rd_row(rd_row),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ready(eat_ready), .eat_hit(eat_hit), .refill_req(refill_req),
    .busy(busy), .food_left(food_left), .all_eaten(all_eaten)
`ifdef FOOD_MAP_STATS_EN
    ,.eaten_total(eaten_total)
`endif
  );

  food_map_server #(.ROWS(2), .COLS(80), .Y_W(6), .X_W(7), .INIT_ROW(80'h1), .CNT_W(13)) dut2 (
    .clk(clk), .rst(rst2), .rd_y(rd_y2), .rd_row(rd_row2),
    .eat_valid(eat_valid2), .eat_x(eat_x2), .eat_y(eat_y2),
    .eat_ready(eat_ready2), .eat_hit(eat_hit2), .refill_req(refill_req2),
    .busy(busy2), .food_left(food_left2), .all_eaten(all_eaten2)
`ifdef FOOD_MAP_STATS_EN
    ,.eaten_total()
`endif
  );

  // Present one eat and record eat_hit / eat_ready after edges N..N+3 (bit i = after edge N+i).
  task automatic run_eat(input logic [6:0] x, input logic [5:0] y,
                         output logic [3:0] hit_tr, output logic [3:0] rdy_tr);
    eat_x = x; eat_y = y; eat_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) eat_valid = 1'b0;
      hit_tr[i] = eat_hit;
      rdy_tr[i] = eat_ready;
    end
  endtask

  task automatic read_row(input logic [5:0] y, output logic [79:0] row);
    rd_y = y;
    @(posedge clk); #1;
    row = rd_row;
  endtask

  task automatic test_reset();
    int cnt;
    logic [79:0] row;
    @(posedge clk); #1;
    tests_run++; if ({rd_row, eat_hit, food_left, all_eaten} !== '0) begin tests_failed++; $display("FAIL reset_zero: got row=%h hit=%b food=%0d all=%b, want all zero", rd_row, eat_hit, food_left, all_eaten); end
    tests_run++; if ({busy, eat_ready} !== 2'b10) begin tests_failed++; $display("FAIL reset_busy: got busy=%b ready=%b, want 1 0", busy, eat_ready); end
    rst = 1'b0; rst2 = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin cnt++; @(posedge clk); #1; end
    tests_run++; if (cnt !== 60) begin tests_failed++; $display("FAIL reset_refill_len: got %0d busy cycles, want 60", cnt); end
    tests_run++; if (food_left !== 13'd2400 || eat_ready !== 1'b1 || all_eaten !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got food=%0d ready=%b all=%b, want 2400 1 0", food_left, eat_ready, all_eaten); end
    read_row(6'd0, row);
    tests_run++; if (row !== INIT) begin tests_failed++; $display("FAIL read_row0: got %h want %h", row, INIT); end
    read_row(6'd59, row);
    tests_run++; if (row !== INIT) begin tests_failed++; $display("FAIL read_row59: got %h want %h", row, INIT); end
    read_row(6'd60, row);
    tests_run++; if (row !== '0) begin tests_failed++; $display("FAIL read_row60: got %h want 0", row); end
  endtask

  task automatic test_eat_hit();
    logic [3:0] h, r;
    logic [79:0] row;
    run_eat(7'd0, 6'd5, h, r);
    tests_run++; if (h !== 4'b0100 || r !== 4'b1100) begin tests_failed++; $display("FAIL eat_hit_timing: got hit=%b ready=%b, want 0100 1100", h, r); end
    tests_run++; if (food_left !== 13'd2399) begin tests_failed++; $display("FAIL eat_hit_count: got %0d want 2399", food_left); end
    read_row(6'd5, row);
    tests_run++; if (row !== ROW5_EAT) begin tests_failed++; $display("FAIL eat_hit_row: got %h want %h", row, ROW5_EAT); end
    run_eat(7'd0, 6'd5, h, r);
    tests_run++; if (h !== 4'b0000 || food_left !== 13'd2399) begin tests_failed++; $display("FAIL eat_repeat: got hit=%b food=%0d, want 0000 2399", h, food_left); end
  endtask

  task automatic test_eat_miss();
    logic [3:0] h, r;
    logic [79:0] row;
    run_eat(7'd1, 6'd5, h, r);
    tests_run++; if (h !== 4'b0000 || food_left !== 13'd2399) begin tests_failed++; $display("FAIL eat_empty_bit: got hit=%b food=%0d, want 0000 2399", h, food_left); end
    run_eat(7'd90, 6'd3, h, r);
    tests_run++; if (h !== 4'b0000 || r !== 4'b1100) begin tests_failed++; $display("FAIL eat_x_range: got hit=%b ready=%b, want 0000 1100", h, r); end
    read_row(6'd3, row);
    tests_run++; if (row !== INIT) begin tests_failed++; $display("FAIL eat_x_range_row: got %h want %h", row, INIT); end
    run_eat(7'd0, 6'd60, h, r);
    tests_run++; if (h !== 4'b0000 || food_left !== 13'd2399) begin tests_failed++; $display("FAIL eat_y_range: got hit=%b food=%0d, want 0000 2399", h, food_left); end
    run_eat(7'd78, 6'd59, h, r);
    tests_run++; if (h !== 4'b0100 || food_left !== 13'd2398) begin tests_failed++; $display("FAIL eat_corner: got hit=%b food=%0d, want 0100 2398", h, food_left); end
    read_row(6'd59, row);
    tests_run++; if (row !== ROW59_EAT) begin tests_failed++; $display("FAIL eat_corner_row: got %h want %h", row, ROW59_EAT); end
  endtask

  task automatic test_refill_priority();
    int cnt;
    logic hit_seen;
    logic [79:0] row;
    eat_x = 7'd0; eat_y = 6'd7; eat_valid = 1'b1; refill_req = 1'b1;
    @(posedge clk); #1;
    eat_valid = 1'b0; refill_req = 1'b0;
    cnt = 0; hit_seen = 1'b0;
    while (busy && cnt < 200) begin cnt++; hit_seen |= eat_hit; @(posedge clk); #1; end
    tests_run++; if (cnt !== 60 || hit_seen !== 1'b0) begin tests_failed++; $display("FAIL refill_prio: got %0d busy cycles hit_seen=%b, want 60 0", cnt, hit_seen); end
    tests_run++; if (food_left !== 13'd2400) begin tests_failed++; $display("FAIL refill_prio_count: got %0d want 2400", food_left); end
    read_row(6'd5, row);
    tests_run++; if (row !== INIT) begin tests_failed++; $display("FAIL refill_restore: got %h want %h", row, INIT); end
  endtask

  task automatic test_refill_during_eat();
    int cnt;
    logic [79:0] row;
    eat_x = 7'd0; eat_y = 6'd5; eat_valid = 1'b1;
    @(posedge clk); #1;
    eat_valid = 1'b0; refill_req = 1'b1;
    @(posedge clk); #1;
    refill_req = 1'b0;
    tests_run++; if (eat_hit !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL pend_wr: got hit=%b busy=%b, want 0 1", eat_hit, busy); end
    @(posedge clk); #1;
    tests_run++; if (eat_hit !== 1'b1 || food_left !== 13'd2399 || busy !== 1'b0) begin tests_failed++; $display("FAIL pend_eat_done: got hit=%b food=%0d busy=%b, want 1 2399 0", eat_hit, food_left, busy); end
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1 || eat_ready !== 1'b0 || food_left !== 13'd0) begin tests_failed++; $display("FAIL pend_refill_start: got busy=%b ready=%b food=%0d, want 1 0 0", busy, eat_ready, food_left); end
    // Mid-refill requests: a second refill must not restart, an eat must be ignored.
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      refill_req = (cnt == 10); eat_valid = (cnt == 10);
      @(posedge clk); #1;
    end
    refill_req = 1'b0; eat_valid = 1'b0;
    tests_run++; if (cnt !== 60) begin tests_failed++; $display("FAIL refill_no_restart: got %0d busy cycles want 60", cnt); end
    @(posedge clk); #1;
    tests_run++; if (food_left !== 13'd2400 || busy !== 1'b0) begin tests_failed++; $display("FAIL refill_ignored_eat: got food=%0d busy=%b, want 2400 0", food_left, busy); end
    read_row(6'd5, row);
    tests_run++; if (row !== INIT) begin tests_failed++; $display("FAIL pend_refill_row: got %h want %h", row, INIT); end
  endtask

  task automatic test_small_map();
    logic [79:0] row;
    tests_run++; if (food_left2 !== 13'd2 || all_eaten2 !== 1'b0) begin tests_failed++; $display("FAIL small_full: got food=%0d all=%b, want 2 0", food_left2, all_eaten2); end
    for (int r = 0; r < 2; r++) begin
      eat_x2 = 7'd0; eat_y2 = 6'(r); eat_valid2 = 1'b1;
      @(posedge clk); #1;
      eat_valid2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (eat_hit2 !== 1'b1 || food_left2 !== 13'(1 - r)) begin tests_failed++; $display("FAIL small_eat%0d: got hit=%b food=%0d, want 1 %0d", r, eat_hit2, food_left2, 1 - r); end
    end
    tests_run++; if (all_eaten2 !== 1'b1) begin tests_failed++; $display("FAIL small_all_eaten: got %b want 1", all_eaten2); end
    rst2 = 1'b1; @(posedge clk); #1; rst2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b1; @(posedge clk); #1; rst2 = 1'b0;
    tests_run++; if (busy2 !== 1'b1 || all_eaten2 !== 1'b0 || food_left2 !== 13'd0) begin tests_failed++; $display("FAIL small_rst_mid: got busy=%b all=%b food=%0d, want 1 0 0", busy2, all_eaten2, food_left2); end
    @(posedge clk); #1;
    tests_run++; if (busy2 !== 1'b1 || all_eaten2 !== 1'b0) begin tests_failed++; $display("FAIL small_restart: got busy=%b all=%b, want 1 0", busy2, all_eaten2); end
    @(posedge clk); #1;
    tests_run++; if (busy2 !== 1'b0 || food_left2 !== 13'd2 || all_eaten2 !== 1'b0) begin tests_failed++; $display("FAIL small_refilled: got busy=%b food=%0d all=%b, want 0 2 0", busy2, food_left2, all_eaten2); end
    rd_y2 = 6'd1; @(posedge clk); #1; row = rd_row2;
    tests_run++; if (row !== 80'h1) begin tests_failed++; $display("FAIL small_row1: got %h want 1", row); end
  endtask

`ifdef FOOD_MAP_STATS_EN
  task automatic test_stats();
    logic [3:0] h, r;
    int cnt;
    run_eat(7'd2, 6'd0, h, r);
    run_eat(7'd4, 6'd0, h, r);
    tests_run++; if (eaten_total !== 16'd5) begin tests_failed++; $display("FAIL stats_total: got %0d want 5", eaten_total); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    tests_run++; if (eaten_total !== 16'd0) begin tests_failed++; $display("FAIL stats_reset: got %0d want 0", eaten_total); end
    cnt = 0;
    while (busy && cnt < 200) begin cnt++; @(posedge clk); #1; end
  endtask
`endif

  initial begin
    test_reset();
    test_eat_hit();
    test_eat_miss();
    test_refill_priority();
    test_refill_during_eat();
    test_small_map();
`ifdef FOOD_MAP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
